// File: rtl/crack_result_collector.sv
// First-match result collector for the cracker array: latches winner, halts cores, flags failure.
// Optional CRACK_TIMEOUT_EN adds a search-cycle limit and a timed_out output.
module crack_result_collector #(
    parameter int NUM_CRACKERS   = 4,
    parameter int IDX_WIDTH      = 2,
    parameter int KEY_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              ack,
    input  logic [NUM_CRACKERS-1:0]           found,
    input  logic [NUM_CRACKERS-1:0]           exhausted,
    input  logic [NUM_CRACKERS*KEY_WIDTH-1:0] cand_key,
    output logic                              halt,
    output logic                              busy,
    output logic                              success,
    output logic                              fail,
    output logic [IDX_WIDTH-1:0]              winner_idx,
    output logic [KEY_WIDTH-1:0]              winner_key
`ifdef CRACK_TIMEOUT_EN
    ,
    output logic                              timed_out
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEARCH    = 2'd1,
        DONE_OK   = 2'd2,
        DONE_FAIL = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_n;
    logic [NUM_CRACKERS-1:0] r_mask;
    logic [NUM_CRACKERS-1:0] w_mask_n;
    logic [NUM_CRACKERS-1:0] w_acc;
    logic                    r_halt, w_halt_n;
    logic                    r_busy, w_busy_n;
    logic                    r_success, w_success_n;
    logic                    r_fail, w_fail_n;
    logic [IDX_WIDTH-1:0]    r_idx, w_idx_n;
    logic [KEY_WIDTH-1:0]    r_key, w_key_n;
    logic [IDX_WIDTH-1:0]    w_win_idx;
    logic [KEY_WIDTH-1:0]    w_win_key;
    logic                    w_any_found;
`ifdef CRACK_TIMEOUT_EN
    logic [31:0]             r_cnt, w_cnt_n;
    logic                    r_tmo, w_tmo_n;
    logic                    w_limit;
`endif

    // Scan high to low so the lowest set index is the one left standing.
    always_comb begin
        w_win_idx = '0;
        w_win_key = '0;
        for (int i = NUM_CRACKERS - 1; i >= 0; i--) begin
            if (found[i]) begin
                w_win_idx = IDX_WIDTH'(i);
                w_win_key = cand_key[i*KEY_WIDTH +: KEY_WIDTH];
            end
        end
    end

    assign w_any_found = |found;
    assign w_acc       = r_mask | exhausted;

`ifdef CRACK_TIMEOUT_EN
    assign w_limit = ({1'b0, r_cnt} + 33'd1) >= 33'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        w_state_n   = r_state;
        w_mask_n    = r_mask;
        w_halt_n    = r_halt;
        w_busy_n    = r_busy;
        w_success_n = r_success;
        w_fail_n    = r_fail;
        w_idx_n     = r_idx;
        w_key_n     = r_key;
`ifdef CRACK_TIMEOUT_EN
        w_cnt_n     = r_cnt;
        w_tmo_n     = r_tmo;
`endif
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_n = SEARCH;
                    w_busy_n  = 1'b1;
                    w_mask_n  = '0;
                    w_idx_n   = '0;
                    w_key_n   = '0;
`ifdef CRACK_TIMEOUT_EN
                    w_cnt_n   = '0;
`endif
                end
            end
            SEARCH: begin
                if (w_any_found) begin
                    w_state_n   = DONE_OK;
                    w_success_n = 1'b1;
                    w_halt_n    = 1'b1;
                    w_busy_n    = 1'b0;
                    w_idx_n     = w_win_idx;
                    w_key_n     = w_win_key;
                end else begin
                    w_mask_n = w_acc;
                    if (&w_acc) begin
                        w_state_n = DONE_FAIL;
                        w_fail_n  = 1'b1;
                        w_halt_n  = 1'b1;
                        w_busy_n  = 1'b0;
                    end
`ifdef CRACK_TIMEOUT_EN
                    else if (w_limit) begin
                        w_state_n = DONE_FAIL;
                        w_fail_n  = 1'b1;
                        w_tmo_n   = 1'b1;
                        w_halt_n  = 1'b1;
                        w_busy_n  = 1'b0;
                    end else begin
                        w_cnt_n = r_cnt + 32'd1;
                    end
`endif
                end
            end
            DONE_OK, DONE_FAIL: begin
                // Winner fields stay put until the next start.
                if (ack) begin
                    w_state_n   = IDLE;
                    w_success_n = 1'b0;
                    w_fail_n    = 1'b0;
                    w_halt_n    = 1'b0;
                    w_busy_n    = 1'b0;
`ifdef CRACK_TIMEOUT_EN
                    w_tmo_n     = 1'b0;
`endif
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mask    <= '0;
            r_halt    <= 1'b0;
            r_busy    <= 1'b0;
            r_success <= 1'b0;
            r_fail    <= 1'b0;
            r_idx     <= '0;
            r_key     <= '0;
`ifdef CRACK_TIMEOUT_EN
            r_cnt     <= '0;
            r_tmo     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_mask    <= w_mask_n;
            r_halt    <= w_halt_n;
            r_busy    <= w_busy_n;
            r_success <= w_success_n;
            r_fail    <= w_fail_n;
            r_idx     <= w_idx_n;
            r_key     <= w_key_n;
`ifdef CRACK_TIMEOUT_EN
            r_cnt     <= w_cnt_n;
            r_tmo     <= w_tmo_n;
`endif
        end
    end

    assign halt       = r_halt;
    assign busy       = r_busy;
    assign success    = r_success;
    assign fail       = r_fail;
    assign winner_idx = r_idx;
    assign winner_key = r_key;
`ifdef CRACK_TIMEOUT_EN
    assign timed_out  = r_tmo;
`endif

endmodule

// File: tb/tb_crack_result_collector.sv
// Directed bench for crack_result_collector (timeout cases need CRACK_TIMEOUT_EN).
module tb_crack_result_collector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         ack;
    logic [3:0]   found;
    logic [3:0]   exhausted;
    logic [127:0] cand_key;
    logic         halt, busy, success, fail;
    logic [1:0]   winner_idx;
    logic [31:0]  winner_key;
`ifdef CRACK_TIMEOUT_EN
    logic         timed_out;
`endif

    int n_chk = 0;
    int n_err = 0;

    crack_result_collector #(
        .NUM_CRACKERS(4),
        .IDX_WIDTH(2),
        .KEY_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .ack(ack),
        .found(found),
        .exhausted(exhausted),
        .cand_key(cand_key),
        .halt(halt),
        .busy(busy),
        .success(success),
        .fail(fail),
        .winner_idx(winner_idx),
        .winner_key(winner_key)
`ifdef CRACK_TIMEOUT_EN
        ,
        .timed_out(timed_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_key(input int i, input logic [31:0] k);
        cand_key[i*32 +: 32] = k;
    endtask

    task automatic chk_flags(input string tag, input logic b, input logic h,
                             input logic s, input logic f);
        chk({tag, ".busy"}, 64'(busy), 64'(b));
        chk({tag, ".halt"}, 64'(halt), 64'(h));
        chk({tag, ".success"}, 64'(success), 64'(s));
        chk({tag, ".fail"}, 64'(fail), 64'(f));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ack = 1'b0;
        found = '0; exhausted = '0; cand_key = '0;
        step(2);
        chk_flags("reset", 0, 0, 0, 0);
        chk("reset.idx", 64'(winner_idx), 64'd0);
        chk("reset.key", 64'(winner_key), 64'd0);
        rst_n = 1'b1;
        step();

        // 1: single found at SEARCH cycle 5
        start = 1'b1; step(); start = 1'b0;
        chk_flags("t1.search", 1, 0, 0, 0);
        step(4);
        found = 4'b0100; set_key(2, 32'hDEADBEEF); step(); found = '0;
        chk_flags("t1.done", 0, 1, 1, 0);
        chk("t1.idx", 64'(winner_idx), 64'd2);
        chk("t1.key", 64'(winner_key), 64'hDEADBEEF);
        found = 4'b0001; exhausted = 4'b1111; step();
        found = '0; exhausted = '0;
        chk("t1.hold.idx", 64'(winner_idx), 64'd2);
        chk_flags("t1.hold", 0, 1, 1, 0);
        ack = 1'b1; step(); ack = 1'b0;
        chk_flags("t1.ack", 0, 0, 0, 0);
        chk("t1.ack.key", 64'(winner_key), 64'hDEADBEEF);

        // 2: multiple found, lowest wins; then ack+start together
        start = 1'b1; step(); start = 1'b0;
        chk("t2.start.idx", 64'(winner_idx), 64'd0);
        chk("t2.start.key", 64'(winner_key), 64'd0);
        found = 4'b1010;
        set_key(1, 32'h11111111); set_key(3, 32'h33333333);
        step(); found = '0;
        chk("t2.idx", 64'(winner_idx), 64'd1);
        chk("t2.key", 64'(winner_key), 64'h11111111);
        ack = 1'b1; start = 1'b1; step(); ack = 1'b0; start = 1'b0;
        chk_flags("t5.ackstart", 0, 0, 0, 0);
        chk("t5.idx", 64'(winner_idx), 64'd1);
        step();
        chk_flags("t5.idle", 0, 0, 0, 0);

        // 3: exhaustion accumulated across cycles
        start = 1'b1; step(); start = 1'b0;
        exhausted = 4'b0001; step();
        exhausted = 4'b0100; step();
        chk_flags("t3.partial", 1, 0, 0, 0);
        exhausted = 4'b1010; step(); exhausted = '0;
        chk_flags("t3.fail", 0, 1, 0, 1);
        ack = 1'b1; step(); ack = 1'b0;
        chk_flags("t3.ack", 0, 0, 0, 0);

        // 4: found beats final exhaustion
        start = 1'b1; step(); start = 1'b0;
        exhausted = 4'b0111; step();
        chk_flags("t4.partial", 1, 0, 0, 0);
        exhausted = 4'b1000; found = 4'b0001; set_key(0, 32'hCAFE0001);
        step(); exhausted = '0; found = '0;
        chk_flags("t4.done", 0, 1, 1, 0);
        chk("t4.idx", 64'(winner_idx), 64'd0);
        chk("t4.key", 64'(winner_key), 64'hCAFE0001);
        ack = 1'b1; step(); ack = 1'b0;

        // 5b: reset mid-search
        start = 1'b1; step(); start = 1'b0;
        step(2);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk_flags("t5.rst", 0, 0, 0, 0);
        chk("t5.rst.key", 64'(winner_key), 64'd0);
        found = 4'b0001; step(); found = '0;
        chk_flags("t5.rst.found", 0, 0, 0, 0);

`ifdef CRACK_TIMEOUT_EN
        // 6: timeout after 8 SEARCH cycles, and found on the 8th wins
        start = 1'b1; step(); start = 1'b0;
        chk("t6.start.to", 64'(timed_out), 64'd0);
        step(7);
        chk_flags("t6.pre", 1, 0, 0, 0);
        step();
        chk_flags("t6.to", 0, 1, 0, 1);
        chk("t6.to.flag", 64'(timed_out), 64'd1);
        ack = 1'b1; step(); ack = 1'b0;
        chk("t6.ack.to", 64'(timed_out), 64'd0);
        start = 1'b1; step(); start = 1'b0;
        step(7);
        found = 4'b0001; set_key(0, 32'h0000BEEF); step(); found = '0;
        chk_flags("t6b", 0, 1, 1, 0);
        chk("t6b.to", 64'(timed_out), 64'd0);
        chk("t6b.key", 64'(winner_key), 64'h0000BEEF);
        ack = 1'b1; step(); ack = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/crack_result_collector.md
Name: crack_result_collector

Overview:
Parametrised success detector for the password-cracking array. It monitors NUM_CRACKERS parallel cracker cores and latches the index and candidate key of the first core to report a match. It broadcasts a halt to all cores and holds the result until the host acknowledges it. It also detects global failure, when every core has exhausted its keyspace without a match.

Parameters:
NUM_CRACKERS, 4, number of cracker cores monitored (>=1)
IDX_WIDTH, 2, width of winner index; must be >= clog2(NUM_CRACKERS), minimum 1
KEY_WIDTH, 32, width of each core's candidate key
TIMEOUT_CYCLES, 1000000, search cycle limit (used only with CRACK_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin a search (sampled in IDLE only)
ack  in  1  host acknowledge of result (sampled in DONE_OK/DONE_FAIL only)
found  in  NUM_CRACKERS  per-core match flag; bit i = core i
exhausted  in  NUM_CRACKERS  per-core keyspace-exhausted flag
cand_key  in  NUM_CRACKERS*KEY_WIDTH  flat candidate keys; core i at [i*KEY_WIDTH +: KEY_WIDTH]
halt  out  1  stop all cores
busy  out  1  search in progress
success  out  1  match latched
fail  out  1  all cores exhausted (or timeout) without match
winner_idx  out  IDX_WIDTH  index of winning core
winner_key  out  KEY_WIDTH  key reported by winning core

Behaviour:
- One clock domain. Reset is synchronous and active-low: rst_n=0 at a rising edge of clk forces state IDLE. All outputs go to 0, and the exhaust mask and counters are cleared. Reset has priority over every other input in every state, including mid-search.
- All outputs are registered. No combinational path from input to output.
- States: IDLE, SEARCH, DONE_OK, DONE_FAIL.
- IDLE: busy=0, halt=0, success=0, fail=0. ack and found are ignored.
  - start=1 -> SEARCH next cycle with busy=1.
  - On that same edge: exhaust mask cleared, winner_idx=0, winner_key=0.
- SEARCH: start and ack are ignored.
  - If any found bit=1, the lowest set index i wins. Next cycle: state DONE_OK, success=1, halt=1, busy=0, winner_idx=i, winner_key=cand_key slice i, sampled on that same edge.
  - Otherwise, mask <= mask | exhausted. If (mask | exhausted) is all ones: next cycle state DONE_FAIL, fail=1, halt=1, busy=0.
  - Latency from found/exhausted to output: exactly 1 cycle.
- Simultaneous events:
  - Multiple found bits: lowest index wins.
  - found and final exhaustion in the same cycle: success wins.
  - exhausted bits may arrive on different cycles and are accumulated. A bit deasserting later does not clear the mask.
- DONE_OK / DONE_FAIL: all outputs held, and found/exhausted are ignored.
  - ack=1 -> IDLE next cycle; success, fail, halt and busy cleared.
  - winner_idx and winner_key are retained until the next start.
  - start and ack in the same cycle: ack is taken, start is ignored. The host must re-assert start in IDLE.
- NUM_CRACKERS=1: the single bit decides; winner_idx is always 0.

Optional Feature:
Macro CRACK_TIMEOUT_EN.
- Defined:
  - Adds output port timed_out (1 bit, reset 0) and a 32-bit search-cycle counter.
  - The counter clears on the start edge and increments each SEARCH cycle.
  - If the SEARCH cycle count reaches TIMEOUT_CYCLES with no found: enter DONE_FAIL with fail=1, timed_out=1, halt=1.
  - found in the final cycle beats timeout.
  - timed_out clears with fail on ack or reset.
- Undefined: no counter, no timed_out port; search is unbounded until found or full exhaustion.

Test Plan:
1. Reset, start pulse; at SEARCH cycle 5 drive found=4'b0100 with core 2 key=32'hDEADBEEF -> next cycle success=1, halt=1, busy=0, winner_idx=2, winner_key=32'hDEADBEEF, fail=0.
2. In SEARCH, found=4'b1010 with keys core1=32'h11111111, core3=32'h33333333 -> winner_idx=1, winner_key=32'h11111111.
3. exhausted=4'b0001, then 4'b0100, then 4'b1010 on separate cycles, then 0 -> fail=1 exactly one cycle after the 4'b1010 cycle; success=0, halt=1.
4. Mask at 4'b0111, then one cycle with exhausted=4'b1000 and found=4'b0001 -> success=1, winner_idx=0, fail=0.
5. In DONE_OK, ack=1 and start=1 together -> IDLE, outputs 0, winner_idx retained. Separately, rst_n=0 for one edge mid-SEARCH -> all outputs 0, state IDLE, and a subsequent found is ignored.
6. With CRACK_TIMEOUT_EN and TIMEOUT_CYCLES=8, start and never assert found/exhausted -> after the 8th SEARCH cycle fail=1, timed_out=1, halt=1. Repeat with found=4'b0001 on the 8th cycle -> success=1, timed_out=0.
